// File: rtl/dmem_arbiter.sv
// Two-port (core/host) arbiter in front of a single-port data memory.
// Optional macro DMEM_ARB_RR_EN: alternate winners on contention; default is core-first priority.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [7:0]  core_addr,
  input  logic [7:0]  core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [7:0]  core_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [7:0]  host_rdata,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [7:0]  mem_rdata,
  input  logic        core_halt,
  output logic [15:0] conflict_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam logic        PORT_CORE = 1'b0;
  localparam logic        PORT_HOST = 1'b1;

  logic          r_last_winner;
  logic          r_rd_pend;
  logic          r_rd_owner;
  logic [CW-1:0] r_conflict_cnt;
  logic [DW-1:0] r_core_rdata;
  logic [DW-1:0] r_host_rdata;

  logic w_contend;
  logic w_core_win;
  logic w_core_gnt;
  logic w_host_gnt;
  logic w_core_rvalid;
  logic w_host_rvalid;

`ifdef DMEM_ARB_RR_EN
  assign w_core_win = (r_last_winner == PORT_HOST);
`else
  logic w_unused_last_winner;
  assign w_core_win           = 1'b1;
  assign w_unused_last_winner = r_last_winner;
`endif

  // Grant decision: halt hands the memory to the host; reset blocks every grant.
  always_comb begin
    w_contend  = 1'b0;
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (!reset) begin
      w_contend  = core_req && host_req && !core_halt;
      w_core_gnt = core_req && !core_halt && (!host_req || w_core_win);
      w_host_gnt = host_req && !w_core_gnt;
    end
  end

  // Memory-side command from the winner; idle drives zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (w_core_gnt) begin
      mem_addr  = core_addr;
      mem_write = core_we;
      mem_read  = !core_we;
      mem_wdata = core_we ? core_wdata : '0;
    end else if (w_host_gnt) begin
      mem_addr  = host_addr;
      mem_write = host_we;
      mem_read  = !host_we;
      mem_wdata = host_we ? host_wdata : '0;
    end
  end

  always_comb begin
    w_core_rvalid = r_rd_pend && (r_rd_owner == PORT_CORE);
    w_host_rvalid = r_rd_pend && (r_rd_owner == PORT_HOST);
  end

  assign core_gnt     = w_core_gnt;
  assign host_gnt     = w_host_gnt;
  assign core_rvalid  = w_core_rvalid;
  assign host_rvalid  = w_host_rvalid;
  assign core_rdata   = w_core_rvalid ? mem_rdata : r_core_rdata;
  assign host_rdata   = w_host_rvalid ? mem_rdata : r_host_rdata;
  assign conflict_cnt = r_conflict_cnt;

  // Winner history, read-response tracking, held read data and contention counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_winner  <= PORT_CORE;
      r_rd_pend      <= 1'b0;
      r_rd_owner     <= PORT_CORE;
      r_conflict_cnt <= '0;
      r_core_rdata   <= '0;
      r_host_rdata   <= '0;
    end else begin
      if (w_core_gnt || w_host_gnt) begin
        r_last_winner <= w_host_gnt ? PORT_HOST : PORT_CORE;
      end
      r_rd_pend <= mem_read;
      if (mem_read) begin
        r_rd_owner <= w_host_gnt ? PORT_HOST : PORT_CORE;
      end
      if (w_core_rvalid) begin
        r_core_rdata <= mem_rdata;
      end
      if (w_host_rvalid) begin
        r_host_rdata <= mem_rdata;
      end
      if (w_contend && (r_conflict_cnt != {CW{1'b1}})) begin
        r_conflict_cnt <= r_conflict_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a per-cycle reference model pushes expectations,
// an independent monitor pops and compares against what the DUT presents.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [7:0]  core_addr = '0, core_wdata = '0, host_addr = '0, host_wdata = '0;
  logic        core_halt = 1'b0;
  logic        core_gnt, core_rvalid, host_gnt, host_rvalid;
  logic [7:0]  core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .core_halt(core_halt), .conflict_cnt(conflict_cnt)
  );

  // Memory device behind the arbiter: one-cycle read latency.
  logic       mem_clear = 1'b1;
  logic [7:0] dev_mem [256];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 8'h00;
    end else begin
      if (mem_write) dev_mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= dev_mem[mem_addr];
    end
  end

  typedef struct packed {
    logic        cg, hg, mrd, mwr;
    logic [7:0]  ma, mwd;
    logic        crv, hrv;
    logic [7:0]  crd, hrd;
    logic [15:0] cnt;
  } cyc_t;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } resp_t;

  cyc_t  cyc_q[$];
  resp_t resp_q[$];

  int tests = 0;
  int fails = 0;

  // Reference state: what the spec says the arbiter remembers.
  logic [7:0]  ref_mem [256];
  logic        m_last, m_pend, m_owner;
  logic [7:0]  m_pdata, m_crd, m_hrd;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, predict every output for this cycle.
  task automatic cyc(input logic rst, input logic halt,
                     input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                     input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                     output logic ocg, output logic ohg);
    cyc_t  e;
    resp_t r;
    logic  cont, win_core, cgn, hgn, we;
    logic [7:0] a, d;
    @(negedge clk);
    reset = rst; core_halt = halt;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    e = '0; cgn = 1'b0; hgn = 1'b0;
    if (rst) begin
      m_last = 1'b0; m_pend = 1'b0; m_owner = 1'b0; m_cnt = '0; m_crd = '0; m_hrd = '0;
    end else begin
      if (m_pend) begin
        r.port = m_owner; r.data = m_pdata;
        resp_q.push_back(r);
        if (m_owner) begin e.hrv = 1'b1; m_hrd = m_pdata; end
        else begin e.crv = 1'b1; m_crd = m_pdata; end
      end
      cont = cr && hr && !halt;
`ifdef DMEM_ARB_RR_EN
      win_core = m_last;
`else
      win_core = 1'b1;
`endif
      if (halt)      begin cgn = 1'b0; hgn = hr; end
      else if (cont) begin cgn = win_core; hgn = !win_core; end
      else           begin cgn = cr; hgn = hr; end
      m_pend = 1'b0;
      if (cgn || hgn) begin
        we = cgn ? cw : hw; a = cgn ? ca : ha; d = cgn ? cd : hd;
        m_last = hgn;
        e.ma = a;
        if (we) begin
          e.mwr = 1'b1; e.mwd = d; ref_mem[a] = d;
        end else begin
          e.mrd = 1'b1; m_pend = 1'b1; m_owner = hgn; m_pdata = ref_mem[a];
        end
      end
      e.cnt = m_cnt;
      if (cont && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.cg = cgn; e.hg = hgn; e.crd = m_crd; e.hrd = m_hrd;
    cyc_q.push_back(e);
    ocg = cgn; ohg = hgn;
  endtask

  // Monitor: samples mid-cycle, independent of the driver.
  initial begin
    cyc_t  e;
    resp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("core_gnt",     16'(core_gnt),    16'(e.cg));
        chk("host_gnt",     16'(host_gnt),    16'(e.hg));
        chk("mem_read",     16'(mem_read),    16'(e.mrd));
        chk("mem_write",    16'(mem_write),   16'(e.mwr));
        chk("mem_addr",     16'(mem_addr),    16'(e.ma));
        chk("mem_wdata",    16'(mem_wdata),   16'(e.mwd));
        chk("core_rvalid",  16'(core_rvalid), 16'(e.crv));
        chk("host_rvalid",  16'(host_rvalid), 16'(e.hrv));
        chk("core_rdata",   16'(core_rdata),  16'(e.crd));
        chk("host_rdata",   16'(host_rdata),  16'(e.hrd));
        chk("conflict_cnt", conflict_cnt,     e.cnt);
      end
      if (core_rvalid || host_rvalid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_rvalid", 16'({core_rvalid, host_rvalid}), 16'h0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_port", 16'({core_rvalid, host_rvalid}), r.port ? 16'h1 : 16'h2);
          chk("resp_data", 16'(host_rvalid ? host_rdata : core_rdata), 16'(r.data));
        end
      end
    end
  end

  initial begin
    logic cg, hg, hold_c, hold_h, halt, rst;
    logic cr, cw, hr, hw;
    logic [7:0] ca, cd, ha, hd;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    m_last = 1'b0; m_pend = 1'b0; m_owner = 1'b0; m_pdata = '0;
    m_crd = '0; m_hrd = '0; m_cnt = '0;
    @(posedge clk); #1 mem_clear = 1'b0;

    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    // Seed 0x10 with A5 through the host, then a fresh reset and a lone core read.
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 8'h10, 8'hA5, cg, hg);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    cyc(0, 0, 1, 0, 8'h10, 0, 0, 0, 0, 0, cg, hg);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    // Continuous contention right after reset.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    repeat (4) cyc(0, 0, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0, cg, hg);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    // Halted core: host owns memory, write then read back.
    cyc(0, 1, 1, 1, 8'h30, 8'h11, 1, 1, 8'h20, 8'h3C, cg, hg);
    cyc(0, 1, 1, 1, 8'h30, 8'h11, 1, 0, 8'h20, 0, cg, hg);
    cyc(0, 1, 1, 1, 8'h30, 8'h11, 0, 0, 0, 0, cg, hg);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    // Host read immediately followed by reset: the response must be dropped.
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 8'h20, 0, cg, hg);
    cyc(1, 0, 1, 0, 8'h05, 0, 1, 0, 8'h06, 0, cg, hg);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    // Saturation of the contention counter.
    @(posedge clk); #1;
    force dut.r_conflict_cnt = 16'hFFFE;
    #1;
    release dut.r_conflict_cnt;
    m_cnt = 16'hFFFE;
    repeat (3) cyc(0, 0, 1, 0, 8'h07, 0, 1, 1, 8'h08, 8'h5E, cg, hg);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);

    // Random traffic honouring the hold-until-granted protocol.
    hold_c = 1'b0; hold_h = 1'b0; halt = 1'b0;
    cr = 0; cw = 0; ca = 0; cd = 0; hr = 0; hw = 0; ha = 0; hd = 0;
    for (int n = 0; n < 600; n++) begin
      if (!hold_c) begin
        cr = ($urandom % 3) != 0; cw = 1'($urandom % 2);
        ca = 8'($urandom % 16);   cd = 8'($urandom);
      end
      if (!hold_h) begin
        hr = ($urandom % 3) != 0; hw = 1'($urandom % 2);
        ha = 8'($urandom % 16);   hd = 8'($urandom);
      end
      if (n % 50 == 0) halt = ($urandom % 3) == 0;
      rst = (n == 300) || (n == 301);
      cyc(rst, halt, cr, cw, ca, cd, hr, hw, ha, hd, cg, hg);
      hold_c = cr && !cg;
      hold_h = hr && !hg;
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cg, hg);
    @(negedge clk); #4;
    chk("cyc_q_drained",  16'(cyc_q.size()),  16'h0);
    chk("resp_q_drained", 16'(resp_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
